sram_write_arbiter: RTL and testbench

Shares the single write port of one `sram_2R1W` (128-bit data, 16-bit address) between several producer engines inside `Top`. Each requester presents beats on a valid/ready handshake. The arbiter grants round-robin, lets a granted requester hold the port for a burst, and drives the SRAM `WE`/`WriteAddress`/`WriteBus` from registers. One instance sits in front of each of M2, M3 and M4.

---
 rtl/sram_write_arbiter_pkg.sv | 13 +
 rtl/sram_write_arbiter_if.sv | 24 ++
 rtl/sram_write_arbiter_rr_picker.sv | 29 ++
 rtl/sram_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_sram_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_write_arbiter_pkg.sv
// Shared types and constants for the SRAM write-port arbiter family.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W   = 16;
    localparam int SRAM_DATA_W   = 128;
    localparam int WRITE_COUNT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_write_arbiter_if.sv
// Requester-side valid/ready bus: packed per-requester beat fields plus the ready vector.
interface sram_write_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (
        output req_valid, req_last, req_addr, req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_last, req_addr, req_data,
        output req_ready
    );
endinterface

// File: rtl/sram_write_arbiter_rr_picker.sv
// Combinational rotate-priority selector: first set bit of req at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    // Scan outward from rr_ptr; the first hit claims the grant and masks later ones.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int   j;
            logic take;
            j     = (int'(rr_ptr) + k) % NUM_REQ;
            take  = req[j] & ~any;
            grant = grant | (NUM_REQ'(take) << j);
            index = take ? IDX_W'(j) : index;
            any   = any | req[j];
        end
    end

endmodule

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter sharing one SRAM write port among NUM_REQ requesters, with burst locking
// and registered WE/WriteAddress/WriteBus.
module sram_write_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    sram_write_arbiter_if.slave      req_bus,
    output logic                     WE,
    output logic [ADDR_W-1:0]        WriteAddress,
    output logic [DATA_W-1:0]        WriteBus,
    output logic                     busy,
    output logic [IDX_W-1:0]         owner,
    output logic [WRITE_COUNT_W-1:0] write_count
);

    localparam int               CNT_W       = $clog2(MAX_BURST + 32'sd1);
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(MAX_BURST - 32'sd1);
    localparam bit               SINGLE_BEAT = (MAX_BURST == 32'sd1);

    arb_state_e               state_r;
    arb_state_e               next_state_s;
    logic [IDX_W-1:0]         rr_ptr_r;
    logic [IDX_W-1:0]         owner_r;
    logic [CNT_W-1:0]         beat_cnt_r;
    logic                     we_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [DATA_W-1:0]        data_r;
    logic                     busy_r;
    logic [WRITE_COUNT_W-1:0] write_count_r;

    logic [NUM_REQ-1:0]       pick_grant_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic                     pick_any_s;
    logic [NUM_REQ-1:0]       ready_s;
    logic [IDX_W-1:0]         sel_s;
    logic                     accept_s;
    logic                     sel_last_s;
    logic [ADDR_W-1:0]        sel_addr_s;
    logic [DATA_W-1:0]        sel_data_s;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 32'sd1) begin
            return '0;
        end else begin
            return idx + IDX_W'(1'b1);
        end
    endfunction

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_bus.req_valid),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_grant_s),
        .index  (pick_idx_s),
        .any    (pick_any_s)
    );

    // Port selection: rotating pick while idle, the locked owner otherwise.
    always_comb begin
        ready_s = '0;
        sel_s   = pick_idx_s;
        case (state_r)
            IDLE: begin
                ready_s = pick_grant_s;
                sel_s   = pick_idx_s;
            end
            LOCK: begin
                ready_s[owner_r] = 1'b1;
                sel_s            = owner_r;
            end
            default: begin
                ready_s = '0;
                sel_s   = pick_idx_s;
            end
        endcase
        ready_s            = reset ? '0 : ready_s;
        accept_s           = |(ready_s & req_bus.req_valid);
        sel_last_s         = req_bus.req_last[sel_s];
        sel_addr_s         = req_bus.req_addr[sel_s*ADDR_W +: ADDR_W];
        sel_data_s         = req_bus.req_data[sel_s*DATA_W +: DATA_W];
        req_bus.req_ready  = ready_s;
    end

    // Next state: lock on a non-final beat, release on last or when the burst cap is reached.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !sel_last_s && !SINGLE_BEAT) begin
                    next_state_s = LOCK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOCK: begin
                if (accept_s && (sel_last_s || beat_cnt_r == LAST_CNT)) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LOCK;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, arbitration bookkeeping and the registered SRAM write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= '0;
            owner_r       <= '0;
            beat_cnt_r    <= '0;
            we_r          <= 1'b0;
            addr_r        <= '0;
            data_r        <= '0;
            busy_r        <= 1'b0;
            write_count_r <= '0;
        end else begin
            state_r       <= next_state_s;
            busy_r        <= (next_state_s == LOCK);
            we_r          <= accept_s;
            write_count_r <= write_count_r + WRITE_COUNT_W'(we_r);
            if (accept_s) begin
                addr_r  <= sel_addr_s;
                data_r  <= sel_data_s;
                owner_r <= sel_s;
                if (next_state_s == IDLE) begin
                    rr_ptr_r   <= next_idx(sel_s);
                    beat_cnt_r <= '0;
                end else begin
                    beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
                end
            end
        end
    end

    assign WE           = we_r;
    assign WriteAddress = addr_r;
    assign WriteBus     = data_r;
    assign busy         = busy_r;
    assign owner        = owner_r;
    assign write_count  = write_count_r;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Bench for sram_write_arbiter: directed scenarios plus random traffic, every cycle compared
// against a queue-free behavioural model of the round-robin/burst rules.
module tb_sram_write_arbiter;
    import sram_arb_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 128;
    localparam int MAXB = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          WE;
    logic [AW-1:0] WriteAddress;
    logic [DW-1:0] WriteBus;
    logic          busy;
    logic [1:0]    owner;
    logic [31:0]   write_count;

    sram_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_bus      (bus),
        .WE           (WE),
        .WriteAddress (WriteAddress),
        .WriteBus     (WriteBus),
        .busy         (busy),
        .owner        (owner),
        .write_count  (write_count)
    );

    // SRAM stand-in capturing whatever the arbiter writes.
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    always @(posedge clock) begin
        if (WE === 1'b1) sram_mem[WriteAddress] = WriteBus;
    end

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  v, l;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // Behavioural model state
    int          m_rr, m_owner, m_beats, last_grant;
    bit          m_locked, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_wc;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.req_valid = v;
        bus.req_last  = l;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = a[i];
            bus.req_data[i*DW +: DW] = d[i];
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] one;
        one = 4'b0001;
        if (reset) return 4'b0000;
        if (m_locked) return one << m_owner;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return one << ((m_rr + k) % N);
        end
        return 4'b0000;
    endfunction

    task automatic model_clear();
        m_rr = 0; m_owner = 0; m_beats = 0; m_locked = 1'b0; m_we = 1'b0;
        m_addr = '0; m_data = '0; m_wc = '0; last_grant = -1;
    endtask

    task automatic model_update(input logic [N-1:0] er);
        int g;
        if (reset) begin
            model_clear();
            return;
        end
        m_wc = m_wc + 32'(m_we);
        g = -1;
        for (int k = 0; k < N; k++) if (er[k] && v[k]) g = k;
        last_grant = g;
        m_we = (g >= 0);
        if (g >= 0) begin
            m_addr = a[g];
            m_data = d[g];
            if (!m_locked) begin
                m_owner = g;
                if (l[g] || MAXB == 1) m_rr = (g + 1) % N;
                else begin m_locked = 1'b1; m_beats = 1; end
            end else begin
                m_beats++;
                if (l[g] || m_beats == MAXB) begin
                    m_locked = 1'b0;
                    m_rr = (m_owner + 1) % N;
                end
            end
        end
    endtask

    // One clock: drive inputs, compare every output with the model, then advance both.
    task automatic step();
        logic [N-1:0] er;
        apply();
        #1;
        er = model_ready();
        chk("req_ready", bus.req_ready, er);
        chk("WE", WE, m_we);
        chk("WriteAddress", WriteAddress, m_addr);
        chk("WriteBus", WriteBus, m_data);
        chk("busy", busy, m_locked);
        chk("owner", owner, m_owner);
        chk("write_count", write_count, m_wc);
        model_update(er);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [DW-1:0] bd [4];
    int n0;
    bit got3;

    initial begin
        model_clear();
        v = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = 16'(i * 16);
            d[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        apply();
        @(posedge clock);
        #1;

        // Reset held three cycles with every requester valid
        v = 4'b1111; l = 4'b1111;
        repeat (3) begin
            step();
            chk("rst_ready", bus.req_ready, 4'b0000);
            chk("rst_we", WE, 1'b0);
            chk("rst_count", write_count, 32'd0);
        end
        reset = 1'b0;
        step();
        chk("first_grant_model", last_grant, 0);
        chk("first_grant_we", WE, 1'b1);
        chk("first_grant_addr", WriteAddress, 16'h0000);

        // Fairness: single-beat requests rotate 0,1,2,3 back to back
        do_reset();
        v = 4'b1111; l = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("fair_we", WE, 1'b1);
            chk("fair_addr", WriteAddress, 16'(16 * (k % 4)));
        end
        v = 4'b0000;
        step();
        chk("fair_count", write_count, 32'd8);

        // Burst lock: req1 four beats while req2 waits
        do_reset();
        v = 4'b0110; l = 4'b0100; a[2] = 16'h0200;
        for (int b = 0; b < 4; b++) begin
            a[1] = 16'(16'h0100 + b);
            d[1] = {$urandom, $urandom, $urandom, $urandom};
            bd[b] = d[1];
            l[1] = (b == 3);
            apply();
            #1;
            chk("burst_req2_blocked", bus.req_ready[2], 1'b0);
            step();
        end
        v[1] = 1'b0;
        step();
        chk("burst_next_grant", last_grant, 2);
        chk("burst_next_addr", WriteAddress, 16'h0200);
        v = 4'b0000;
        step();
        step();
        for (int b = 0; b < 4; b++) begin
            chk("burst_mem", sram_mem[16'(16'h0100 + b)], bd[b]);
        end

        // Forced release after MAX_BURST beats
        do_reset();
        v = 4'b1001; l = 4'b1000; a[0] = 16'h0300; a[3] = 16'h0330;
        n0 = 0; got3 = 1'b0;
        for (int c = 0; c < 40 && !got3; c++) begin
            d[0] = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (last_grant == 0) n0++;
            else if (last_grant == 3) got3 = 1'b1;
        end
        chk("forced_req3_granted", got3, 1'b1);
        chk("forced_beats", n0, 16);
        step();
        chk("forced_return", last_grant, 0);

        // Owner stall, then reset in the middle of the burst
        do_reset();
        v = 4'b0010; l = 4'b0000; a[1] = 16'h0400;
        step();
        a[1] = 16'h0401;
        step();
        v = 4'b0000;
        repeat (2) begin
            step();
            chk("stall_we", WE, 1'b0);
            chk("stall_busy", busy, 1'b1);
        end
        v = 4'b0010; a[1] = 16'h0402;
        step();
        reset = 1'b1;
        step();
        chk("midrst_we", WE, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_count", write_count, 32'd0);
        chk("midrst_owner", owner, 2'd0);
        reset = 1'b0;
        v = 4'b0011; l = 4'b0011; a[0] = 16'h0500;
        step();
        chk("midrst_rr_grant", last_grant, 0);
        chk("midrst_rr_addr", WriteAddress, 16'h0500);

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            v = 4'($urandom);
            l = 4'($urandom & $urandom & $urandom);
            for (int i = 0; i < N; i++) begin
                a[i] = 16'($urandom);
                d[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
